demux_reg_bank: RTL and testbench

//  Write-side complement of the bus-select mux: one SIZE-bit input bus is demultiplexed into one of

---
 rtl/demux_reg_bank_pkg.sv | 14 +
 rtl/onehot_decoder.sv | 15 +
 rtl/demux_reg_bank.sv | 101 ++++++++++
 tb/tb_demux_reg_bank.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_reg_bank_pkg.sv
// Shared CompactRISC16 register-bank constants and the bank FSM state encoding.
// Imported by demux_reg_bank and its testbench.
package demux_reg_bank_pkg;

    localparam int CR16_WORD_W     = 16;
    localparam int CR16_REG_CNT    = 16;
    localparam int CR16_REG_ADDR_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/onehot_decoder.sv
// Address to one-hot enable decoder; all outputs low when en is low.
module onehot_decoder #(
    parameter int ADDR_W = 4
) (
    input  logic                 en,
    input  logic [ADDR_W-1:0]    addr,
    output logic [2**ADDR_W-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[addr] = 1'b1;
    end

endmodule

// File: rtl/demux_reg_bank.sv
// Register bank written through a valid/ready demux, with a one-register-per-cycle clear sweep.
// Optional macro DEMUX_REG_BANK_BYPASS_EN forwards an accepted write to matching read ports.
//
// state    | meaning
// ST_IDLE  | writes accepted (in_ready=1), waiting for clr_req
// ST_CLEAR | sweep zeroes reg[cnt] each cycle, writes refused
module demux_reg_bank
    import demux_reg_bank_pkg::*;
#(
    parameter int SIZE   = CR16_WORD_W,
    parameter int REGS   = CR16_REG_CNT,
    parameter int ADDR_W = $clog2(REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [SIZE-1:0]   in_data,
    input  logic              clr_req,
    output logic              clr_busy,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [SIZE-1:0]   rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [SIZE-1:0]   rd_data_b
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              wr_acc;
    logic              sweep_en;
    logic [REGS-1:0]   wr_oh;
    logic [REGS-1:0]   sweep_oh;
    logic [SIZE-1:0]   bank [REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        in_ready  = 1'b0;
        clr_busy  = 1'b0;
        sweep_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (clr_req) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                clr_busy = 1'b1;
                sweep_en = 1'b1;
                cnt_nxt  = cnt + 1'b1;
                // counter wraps to 0 on the same edge the sweep ends
                if (cnt == ADDR_W'(REGS - 1)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign wr_acc = in_valid && in_ready;

    onehot_decoder #(.ADDR_W(ADDR_W)) u_wr_dec (
        .en     (wr_acc),
        .addr   (in_addr),
        .onehot (wr_oh)
    );

    onehot_decoder #(.ADDR_W(ADDR_W)) u_sweep_dec (
        .en     (sweep_en),
        .addr   (cnt),
        .onehot (sweep_oh)
    );

    always_ff @(posedge clk) begin
        for (int i = 0; i < REGS; i++) begin
            if (reset || sweep_oh[i]) bank[i] <= '0;
            else if (wr_oh[i])        bank[i] <= in_data;
        end
    end

`ifdef DEMUX_REG_BANK_BYPASS_EN
    // sweep writes never reach wr_acc, so only handshake writes are forwarded
    assign rd_data_a = (wr_acc && rd_addr_a == in_addr) ? in_data : bank[rd_addr_a];
    assign rd_data_b = (wr_acc && rd_addr_b == in_addr) ? in_data : bank[rd_addr_b];
`else
    assign rd_data_a = bank[rd_addr_a];
    assign rd_data_b = bank[rd_addr_b];
`endif

endmodule

// File: tb/tb_demux_reg_bank.sv
// Directed self-checking bench for demux_reg_bank with a reference bank model and write scoreboard.
module tb_demux_reg_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_addr;
    logic [15:0] in_data;
    logic        clr_req;
    logic        clr_busy;
    logic [3:0]  rd_addr_a;
    logic [15:0] rd_data_a;
    logic [3:0]  rd_addr_b;
    logic [15:0] rd_data_b;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t         sb[$];
    logic [15:0] model [16];
    int          n_cmp = 0;
    int          n_bad = 0;

    demux_reg_bank dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i);
            rd_addr_b = 4'(15 - i);
            #1;
            chk($sformatf("%s_a%0d", tag, i), rd_data_a, model[i]);
            chk($sformatf("%s_b%0d", tag, 15 - i), rd_data_b, model[15 - i]);
        end
    endtask

    // single accepted write; expectation goes to the scoreboard and is popped once visible
    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        wr_t e;
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        #1;
        chk("wr_ready", {15'd0, in_ready}, 16'd1);
        e.addr = a;
        e.data = d;
        sb.push_back(e);
        tick();
        in_valid = 1'b0;
        model[a] = d;
        e = sb.pop_front();
        rd_addr_a = e.addr;
        #1;
        chk($sformatf("wr_rd%0d", e.addr), rd_data_a, e.data);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 16'h0;
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_addr   = 4'd0;
        in_data   = 16'h0;
        clr_req   = 1'b0;
        rd_addr_a = 4'd0;
        rd_addr_b = 4'd0;

        // 1: reset state
        do_reset();
        #1;
        chk("rst_ready", {15'd0, in_ready}, 16'd1);
        chk("rst_busy", {15'd0, clr_busy}, 16'd0);
        check_all("rst");

        // 2: single write, other registers untouched
        tick();
        wr(4'd5, 16'hBEEF);
        check_all("w5");

        // 3: fill then full sweep; writes offered during sweep must be refused
        tick();
        for (int i = 0; i < 16; i++) wr(4'(i), 16'h1000 + 16'(i));
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1;
            in_addr  = 4'd15;
            in_data  = 16'hFFFF;
            #1;
            chk($sformatf("sw_busy%0d", k), {15'd0, clr_busy}, 16'd1);
            chk($sformatf("sw_ready%0d", k), {15'd0, in_ready}, 16'd0);
            tick();
            model[k]  = 16'h0;
            in_valid  = 1'b0;
            rd_addr_a = 4'(k);
            rd_addr_b = 4'(k + 1);
            #1;
            chk($sformatf("sw_clr%0d", k), rd_data_a, model[k]);
            chk($sformatf("sw_keep%0d", (k + 1) % 16), rd_data_b, model[(k + 1) % 16]);
        end
        chk("sw_done_busy", {15'd0, clr_busy}, 16'd0);
        chk("sw_done_ready", {15'd0, in_ready}, 16'd1);
        check_all("sw_end");

        // 4: reset mid-sweep
        tick();
        for (int i = 0; i < 16; i++) wr(4'(i), 16'h2000 + 16'(i));
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        #1;
        chk("mid_busy", {15'd0, clr_busy}, 16'd1);
        do_reset();
        #1;
        chk("mid_rst_ready", {15'd0, in_ready}, 16'd1);
        chk("mid_rst_busy", {15'd0, clr_busy}, 16'd0);
        check_all("mid_rst");

        // 5: read-during-write collision
        tick();
        rd_addr_a = 4'd3;
        rd_addr_b = 4'd3;
        in_valid  = 1'b1;
        in_addr   = 4'd3;
        in_data   = 16'hA5A5;
        #1;
`ifdef DEMUX_REG_BANK_BYPASS_EN
        chk("rdw_same_a", rd_data_a, 16'hA5A5);
        chk("rdw_same_b", rd_data_b, 16'hA5A5);
`else
        chk("rdw_same_a", rd_data_a, 16'h0000);
        chk("rdw_same_b", rd_data_b, 16'h0000);
`endif
        tick();
        in_valid = 1'b0;
        model[3] = 16'hA5A5;
        #1;
        chk("rdw_next_a", rd_data_a, 16'hA5A5);

        // 6: write committed in the clr_req cycle, then swept away
        tick();
        clr_req  = 1'b1;
        in_valid = 1'b1;
        in_addr  = 4'd9;
        in_data  = 16'h1234;
        tick();
        clr_req   = 1'b0;
        in_valid  = 1'b0;
        rd_addr_b = 4'd9;
        #1;
        chk("clrw_commit", rd_data_b, 16'h1234);
        chk("clrw_busy", {15'd0, clr_busy}, 16'd1);
        for (int k = 0; k < 16; k++) tick();
        for (int i = 0; i < 16; i++) model[i] = 16'h0;
        #1;
        chk("clrw_done_busy", {15'd0, clr_busy}, 16'd0);
        check_all("clrw_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
